// File: rtl/dram_pkg.sv
// Shared types, defaults and the address encoder for the DRAM read-return path.
package dram_pkg;

  localparam int WORD_W          = 32;
  localparam int IGNORE_BITS     = 1;
  localparam int RANK_BITS       = 1;
  localparam int ROW_BITS        = 14;
  localparam int BANK_BITS       = 2;
  localparam int BANK_GROUP_BITS = 2;
  localparam int COLUMN_BITS     = 10;
  localparam int OFFSET_BITS     = 2;

  localparam int DEF_DEPTH     = 8;
  localparam int DEF_BURST_LEN = 8;
  localparam int DEF_DATA_W    = 64;

  localparam bit ENC_OK =
    (IGNORE_BITS + RANK_BITS + ROW_BITS + BANK_BITS +
     BANK_GROUP_BITS + COLUMN_BITS + OFFSET_BITS) == WORD_W;

  typedef logic [WORD_W-1:0] word_t;

  // Exact inverse of the decoder's address split.
  function automatic word_t encode_addr(
    input logic [IGNORE_BITS-1:0]     ig,
    input logic [RANK_BITS-1:0]       rk,
    input logic [ROW_BITS-1:0]        rw,
    input logic [BANK_BITS-1:0]       bk,
    input logic [BANK_GROUP_BITS-1:0] bg,
    input logic [COLUMN_BITS-1:0]     cl,
    input logic [OFFSET_BITS-1:0]     of
  );
    return {ig, rk, rw, bk, bg, cl, of};
  endfunction

endpackage

// File: rtl/dram_rd_fifo.sv
// In-order queue of outstanding READ addresses.
module dram_rd_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr[AW-1:0]] <= din;
  end

  assign head  = mem[rptr[AW-1:0]];
  assign empty = (wptr == rptr);
  assign full  = (wptr[AW-1:0] == rptr[AW-1:0]) &&
                 (wptr[AW] != rptr[AW]);

endmodule

// File: rtl/dram_read_return_tracker.sv
// Tags returning READ data beats with the word address of the owning READ.
module dram_read_return_tracker
  import dram_pkg::*;
#(
  parameter int DEPTH     = DEF_DEPTH,
  parameter int BURST_LEN = DEF_BURST_LEN,
  parameter int DATA_W    = DEF_DATA_W
) (
  input  logic                       CLK,
  input  logic                       nRST,
  input  logic                       rd_issue,
  input  logic [RANK_BITS-1:0]       rank,
  input  logic [BANK_GROUP_BITS-1:0] BG,
  input  logic [BANK_BITS-1:0]       bank,
  input  logic [ROW_BITS-1:0]        row,
  input  logic [COLUMN_BITS-1:0]     col,
  input  logic [OFFSET_BITS-1:0]     offset,
  input  logic [IGNORE_BITS-1:0]     ignore,
  input  logic                       dq_valid,
  input  logic [DATA_W-1:0]          dq_data,
  output logic                       full,
  output logic                       resp_valid,
  output word_t                      resp_addr,
  output logic [DATA_W-1:0]          resp_data,
  output logic                       resp_last,
  output logic                       overflow_err,
  output logic                       underflow_err
);

  localparam int CW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(BURST_LEN - 1);

  if (!ENC_OK) begin : g_enc_chk
    $error("address field widths do not sum to WORD_W");
  end

  logic [CW-1:0] cnt;
  logic          empty;
  logic          push;
  logic          beat;
  logic          last_beat;
  word_t         head;
  word_t         waddr;

  assign waddr = encode_addr(ignore, rank, row, bank, BG, col, offset);
  assign push  = rd_issue && !full;

  // A beat only matches an entry that was queued before this edge.
  assign beat      = dq_valid && !empty;
  assign last_beat = beat && (cnt == LAST_CNT);

  dram_rd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WORD_W)
  ) u_fifo (
    .clk   (CLK),
    .rst_n (nRST),
    .push  (push),
    .din   (waddr),
    .pop   (last_beat),
    .head  (head),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cnt           <= '0;
      resp_valid    <= 1'b0;
      resp_addr     <= '0;
      resp_data     <= '0;
      resp_last     <= 1'b0;
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
    end else begin
      resp_valid <= beat;
      resp_last  <= last_beat;
      if (beat) begin
        resp_addr <= head;
        resp_data <= dq_data;
        cnt       <= last_beat ? '0 : cnt + 1'b1;
      end
      if (rd_issue && full)      overflow_err  <= 1'b1;
      if (dq_valid && empty)     underflow_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dram_read_return_tracker.sv
// Randomised and directed checks of the read-return tracker against a queue model.
module tb_dram_read_return_tracker;
  import dram_pkg::*;

  localparam int DEPTH = 8;
  localparam int BL    = 8;
  localparam int DW    = 64;

  logic                       CLK = 1'b0;
  logic                       nRST = 1'b0;
  logic                       rd_issue = 1'b0;
  logic [RANK_BITS-1:0]       rank = '0;
  logic [BANK_GROUP_BITS-1:0] BG = '0;
  logic [BANK_BITS-1:0]       bank = '0;
  logic [ROW_BITS-1:0]        row = '0;
  logic [COLUMN_BITS-1:0]     col = '0;
  logic [OFFSET_BITS-1:0]     offset = '0;
  logic [IGNORE_BITS-1:0]     ignore = '0;
  logic                       dq_valid = 1'b0;
  logic [DW-1:0]              dq_data = '0;
  logic                       full;
  logic                       resp_valid;
  logic [WORD_W-1:0]          resp_addr;
  logic [DW-1:0]              resp_data;
  logic                       resp_last;
  logic                       overflow_err;
  logic                       underflow_err;

  int errors = 0;
  int checks = 0;

  dram_read_return_tracker #(
    .DEPTH(DEPTH), .BURST_LEN(BL), .DATA_W(DW)
  ) dut (
    .CLK(CLK), .nRST(nRST), .rd_issue(rd_issue),
    .rank(rank), .BG(BG), .bank(bank), .row(row),
    .col(col), .offset(offset), .ignore(ignore),
    .dq_valid(dq_valid), .dq_data(dq_data),
    .full(full), .resp_valid(resp_valid),
    .resp_addr(resp_addr), .resp_data(resp_data),
    .resp_last(resp_last), .overflow_err(overflow_err),
    .underflow_err(underflow_err)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string n, input logic [63:0] a,
                     input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask

  // Address as a plain weighted sum of the fields.
  function automatic logic [31:0] model_enc();
    longint v;
    v = longint'(ignore) * (64'd1 << 31) + longint'(rank) * (64'd1 << 30)
      + longint'(row) * (64'd1 << 16) + longint'(bank) * (64'd1 << 14)
      + longint'(BG) * (64'd1 << 12) + longint'(col) * 4 + longint'(offset);
    return v[31:0];
  endfunction

  logic [31:0] mq[$];
  int          mcnt = 0;
  logic        e_valid = 0, e_last = 0, e_ovf = 0, e_unf = 0;
  logic [31:0] e_addr = 0;
  logic [DW-1:0] e_data = 0;

  always @(negedge nRST) begin
    mq.delete();
    mcnt = 0; e_valid = 0; e_last = 0; e_ovf = 0; e_unf = 0;
    e_addr = 0; e_data = 0;
  end

  always @(posedge CLK) begin
    if (nRST) begin
      bit was_full, was_empty;
      was_full  = (mq.size() == DEPTH);
      was_empty = (mq.size() == 0);
      e_valid = 0;
      e_last  = 0;
      if (dq_valid) begin
        if (was_empty) e_unf = 1;
        else begin
          e_valid = 1;
          e_addr  = mq[0];
          e_data  = dq_data;
          e_last  = (mcnt == BL - 1);
          mcnt    = (mcnt + 1) % BL;
          if (e_last) void'(mq.pop_front());
        end
      end
      if (rd_issue) begin
        if (was_full) e_ovf = 1;
        else mq.push_back(model_enc());
      end
    end
    #1;
    chk("full", full, (mq.size() == DEPTH));
    chk("resp_valid", resp_valid, e_valid);
    chk("resp_last", resp_last, e_last);
    chk("resp_addr", resp_addr, e_addr);
    if (e_valid) chk("resp_data", resp_data, e_data);
    chk("overflow_err", overflow_err, e_ovf);
    chk("underflow_err", underflow_err, e_unf);
  end

  task automatic rand_fields();
    ignore = IGNORE_BITS'($urandom); rank = RANK_BITS'($urandom);
    row = ROW_BITS'($urandom); bank = BANK_BITS'($urandom);
    BG = BANK_GROUP_BITS'($urandom); col = COLUMN_BITS'($urandom);
    offset = OFFSET_BITS'($urandom);
  endtask

  task automatic drive(input bit iss, input bit dq);
    @(negedge CLK);
    rd_issue = iss;
    dq_valid = dq;
    dq_data  = {$urandom, $urandom};
  endtask

  task automatic after_edge();
    @(posedge CLK);
    #2;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    nRST = 1'b0; rd_issue = 0; dq_valid = 0;
    repeat (2) @(negedge CLK);
    nRST = 1'b1;
  endtask

  initial begin
    logic [31:0] a_new;
    int got;
    repeat (2) @(negedge CLK);
    #1;
    chk("rst_valid", resp_valid, 0);
    chk("rst_addr", resp_addr, 0);
    chk("rst_full", full, 0);
    nRST = 1'b1;

    // Single READ with known fields.
    ignore = 0; rank = 1; BG = 2; bank = 3; row = 14'h1A5;
    col = 10'h40; offset = 0;
    drive(1, 0);
    for (int i = 0; i < BL; i++) begin
      drive(0, 1);
      after_edge();
      chk("t1_addr", resp_addr, 32'h41A5E100);
      chk("t1_last", resp_last, (i == BL - 1));
    end
    drive(0, 0);

    // Fill the queue, then one more issue.
    for (int i = 0; i < DEPTH; i++) begin
      rand_fields();
      drive(1, 0);
    end
    after_edge();
    chk("t2_full", full, 1);
    rand_fields();
    drive(1, 0);
    after_edge();
    chk("t2_ovf", overflow_err, 1);
    for (int i = 0; i < DEPTH * BL; i++) drive(0, 1);
    drive(0, 0);
    after_edge();
    chk("t2_drained_full", full, 0);

    // Four READs, 32 beats with random gaps.
    for (int i = 0; i < 4; i++) begin
      rand_fields();
      drive(1, 0);
    end
    got = 0;
    for (int c = 0; c < 500 && got < 4 * BL; c++) begin
      bit v;
      v = ($urandom_range(0, 2) != 0);
      drive(0, v);
      if (v) got++;
    end
    chk("t3_beats", got, 4 * BL);
    drive(0, 0);

    // Pop of A coincides with push of C while B is queued.
    rand_fields(); drive(1, 0);
    rand_fields(); drive(1, 0);
    for (int i = 0; i < BL - 1; i++) drive(0, 1);
    rand_fields();
    drive(1, 1);
    for (int i = 0; i < 2 * BL; i++) drive(0, 1);
    drive(0, 0);

    // Underflow after reset.
    do_reset();
    drive(0, 1);
    drive(0, 0);
    after_edge();
    chk("t5_unf", underflow_err, 1);
    chk("t5_valid", resp_valid, 0);
    repeat (3) drive(0, 0);
    chk("t5_unf_sticky", underflow_err, 1);

    // Reset during the third beat of a burst.
    do_reset();
    rand_fields(); drive(1, 0);
    drive(0, 1); drive(0, 1); drive(0, 1);
    nRST = 1'b0;
    #1;
    chk("t6_rst_valid", resp_valid, 0);
    chk("t6_rst_addr", resp_addr, 0);
    chk("t6_rst_data", resp_data, 0);
    dq_valid = 0;
    repeat (2) @(negedge CLK);
    nRST = 1'b1;
    ignore = 1; rank = 0; BG = 1; bank = 2; row = 14'h0F3;
    col = 10'h3FF; offset = 3;
    a_new = 32'h80F39FFF;
    drive(1, 0);
    for (int i = 0; i < BL; i++) begin
      drive(0, 1);
      after_edge();
      chk("t6_addr", resp_addr, a_new);
    end
    chk("t6_unf", underflow_err, 0);
    drive(0, 0);

    // Random traffic.
    for (int c = 0; c < 1500; c++) begin
      bit iss;
      iss = ($urandom_range(0, 3) == 0);
      if (iss) rand_fields();
      drive(iss, ($urandom_range(0, 1) == 1));
    end
    drive(0, 0);
    after_edge();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
